alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter BUS_WIDTH, default 8, SHALL set the instruction width; values below 8 are unsupported.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 instr_valid  input  1  SHALL mean an instruction is offered.
REQ-005 instr  input  BUS_WIDTH  SHALL be the instruction word: opcode = instr[BUS_WIDTH-1:BUS_WIDTH-3], count = instr[3:0].
REQ-006 instr_ready  output  1  SHALL mean the sequencer accepts instr this cycle.
REQ-007 reg_en  output  3  SHALL be the datapath register enables: bit0 = mult B, bit1 = mult D, bit2 = op_e.
REQ-008 f_load  output  1  SHALL select the op_e source: 0 = sw, 1 = imm.
REQ-009 f_reg_e  output  1  SHALL select the adder second operand: 0 = op_e register, 1 = data_a.
REQ-010 f_clr  output  1  SHALL clear the multiply stage.
REQ-011 res_valid  output  1  SHALL pulse high for the single cycle in which the datapath result is valid.

Function
REQ-012 Handshake: an instruction SHALL be accepted on a rising edge where instr_valid && instr_ready; instr is ignored otherwise.
REQ-013 instr_ready SHALL be high only in IDLE, so throughput is at most one instruction per two cycles.
REQ-014 States SHALL be IDLE, EXEC, WAIT, MAC_B, MAC_D and MAC_R.
REQ-015 Transitions out of IDLE on accept:
- NOP goes to WAIT.
- MAC goes to MAC_B.
- All other opcodes go to EXEC.
REQ-016 All control outputs SHALL be registered and become active in the cycle after the accepting edge; outputs not listed for a state SHALL be 0.
REQ-017 Opcode map for the EXEC cycle:
- 000 NOP: no controls.
- 001 LDE_SW: reg_en = 100, f_load = 0.
- 010 LDE_IMM: reg_en = 100, f_load = 1.
- 011 LDB: reg_en = 001.
- 100 LDD: reg_en = 010.
- 101 CLR: f_clr = 1.
- 110 MAC: see REQ-019.
- 111 ADDA: f_reg_e = 1, res_valid = 1.
REQ-018 EXEC SHALL last exactly one cycle and then return to IDLE.
REQ-019 MAC sequence, one cycle per state:
- MAC_B: reg_en = 001.
- MAC_D: reg_en = 010.
- MAC_R: f_reg_e = 0, res_valid = 1.
- Then return to IDLE.
REQ-020 WAIT SHALL load a 4-bit down-counter with count and hold all controls at 0 for count+1 cycles before returning to IDLE; count = 0 gives 1 cycle and count = 15 gives 16.
REQ-021 Bits instr[4:0] SHALL be ignored by every opcode except NOP, which uses instr[3:0].
REQ-022 res_valid SHALL never be high in two consecutive cycles.
REQ-023 instr_valid changing while the sequencer is busy SHALL NOT alter the sequence in progress.

Reset
REQ-024 While rst is high:
- State SHALL be IDLE and the counter 0.
- reg_en, f_load, f_reg_e, f_clr and res_valid SHALL be 0.
- instr_ready SHALL be 0.
REQ-025 instr_ready SHALL rise on the first rising clk edge after rst deasserts.
REQ-026 Reset asserted mid-MAC or mid-WAIT SHALL force all outputs to 0 immediately, without waiting for clk, and abandon the sequence with no res_valid pulse.

Structure
REQ-027 Package alu_seq_pkg SHALL hold:
- the opcode enum (3 bits);
- the state enum;
- the reg_en bit index constants (REG_B = 0, REG_D = 1, REG_E = 2).
REQ-028 alu_seq SHALL be a single module (FSM plus counter) with no sub-modules; it drives the ALU control inputs directly.

Verification
REQ-029 Reset release then LDE_IMM (instr = 0x40) offered: accepted on the first ready edge; next cycle reg_en = 100 and f_load = 1 for exactly one cycle; instr_ready returns high the cycle after.
REQ-030 MAC (instr = 0xC0) accepted: three consecutive cycles show reg_en = 001, then 010, then 000 with res_valid = 1; instr_ready stays low for all three.
REQ-031 NOP with count = 5 (instr = 0x05): six cycles of all-zero controls; NOP with count = 0: one cycle.
REQ-032 instr_valid held high with ADDA (0xE0) continuously: accepted every second cycle; f_reg_e and res_valid pulse on alternate cycles, never back-to-back.
REQ-033 rst asserted in the MAC_D cycle: all outputs 0 before the next edge, no res_valid; after release the next MAC completes normally.
REQ-034 An instruction offered while busy (instr_valid = 1 during MAC_B) is not accepted until IDLE; the running sequence is unchanged.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU control sequencer.
package alu_seq_pkg;

  // 3-bit instruction opcodes (instr[BUS_WIDTH-1:BUS_WIDTH-3]).
  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_LDE_SW  = 3'b001,
    OP_LDE_IMM = 3'b010,
    OP_LDB     = 3'b011,
    OP_LDD     = 3'b100,
    OP_CLR     = 3'b101,
    OP_MAC     = 3'b110,
    OP_ADDA    = 3'b111
  } opcode_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_MAC_B = 3'd3,
    ST_MAC_D = 3'd4,
    ST_MAC_R = 3'd5
  } state_e;

  // Bit positions inside reg_en.
  localparam int REG_B = 0;
  localparam int REG_D = 1;
  localparam int REG_E = 2;

  // Registered control bundle driven onto the datapath.
  typedef struct packed {
    logic       ready;
    logic [2:0] reg_en;
    logic       f_load;
    logic       f_reg_e;
    logic       f_clr;
    logic       res_valid;
  } ctrl_t;

endpackage

// File: rtl/alu_seq.sv
// ALU control sequencer: accepts one instruction at a time and plays out the
// register-enable / mux-select pattern for it, one control word per cycle.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  input  logic [BUS_WIDTH-1:0] instr,
  output logic                 instr_ready,
  output logic [2:0]           reg_en,
  output logic                 f_load,
  output logic                 f_reg_e,
  output logic                 f_clr,
  output logic                 res_valid
);

  state_e     state_q, state_d;
  opcode_e    op_q, op_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       accept;

  // Bits between the opcode field and the count field carry no meaning.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[BUS_WIDTH-4:4];

  // ready comes straight from the output register, so it is low during reset
  // and rises on the first edge after release.
  assign accept = instr_valid && ctrl_q.ready;

  // Next-state, opcode latch and WAIT counter.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can leave
    // it unassigned and infer a latch.
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = opcode_e'(instr[BUS_WIDTH-1 -: 3]);
          if (op_d == OP_NOP) begin
            state_d = ST_WAIT;
            cnt_d   = instr[3:0];
          end else if (op_d == OP_MAC) begin
            state_d = ST_MAC_B;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC:  state_d = ST_IDLE;
      ST_WAIT: begin
        // count+1 cycles in total: leave when the counter has reached zero.
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_MAC_B: state_d = ST_MAC_D;
      ST_MAC_D: state_d = ST_MAC_R;
      ST_MAC_R: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control word for the state being entered, registered on the same edge.
  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      ST_IDLE:  ctrl_d.ready = 1'b1;
      ST_EXEC: begin
        unique case (op_d)
          OP_LDE_SW:  ctrl_d.reg_en[REG_E] = 1'b1;
          OP_LDE_IMM: begin
            ctrl_d.reg_en[REG_E] = 1'b1;
            ctrl_d.f_load        = 1'b1;
          end
          OP_LDB:     ctrl_d.reg_en[REG_B] = 1'b1;
          OP_LDD:     ctrl_d.reg_en[REG_D] = 1'b1;
          OP_CLR:     ctrl_d.f_clr         = 1'b1;
          OP_ADDA: begin
            ctrl_d.f_reg_e   = 1'b1;
            ctrl_d.res_valid = 1'b1;
          end
          default:    ctrl_d = '0;
        endcase
      end
      ST_MAC_B: ctrl_d.reg_en[REG_B] = 1'b1;
      ST_MAC_D: ctrl_d.reg_en[REG_D] = 1'b1;
      ST_MAC_R: ctrl_d.res_valid     = 1'b1;
      default:  ctrl_d = '0;
    endcase
  end

  // State, opcode, counter and control registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample their inputs from before the edge.
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= 4'd0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign instr_ready = ctrl_q.ready;
  assign reg_en      = ctrl_q.reg_en;
  assign f_load      = ctrl_q.f_load;
  assign f_reg_e     = ctrl_q.f_reg_e;
  assign f_clr       = ctrl_q.f_clr;
  assign res_valid   = ctrl_q.res_valid;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq. Inputs change and outputs are sampled on the
// falling edge; observed word = {instr_ready, reg_en, f_load, f_reg_e, f_clr, res_valid}.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic [2:0] reg_en;
  logic       f_load, f_reg_e, f_clr, res_valid;

  int total = 0;
  int bad   = 0;

  alu_seq #(.BUS_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .reg_en(reg_en), .f_load(f_load),
    .f_reg_e(f_reg_e), .f_clr(f_clr), .res_valid(res_valid)
  );

  always #5 clk = ~clk;

  // Expected words.
  localparam logic [7:0] W_ZERO = 8'h00;
  localparam logic [7:0] W_IDLE = 8'h80;
  localparam logic [7:0] W_LSW  = 8'h40;
  localparam logic [7:0] W_LIMM = 8'h48;
  localparam logic [7:0] W_B    = 8'h10;
  localparam logic [7:0] W_D    = 8'h20;
  localparam logic [7:0] W_CLR  = 8'h02;
  localparam logic [7:0] W_ADDA = 8'h05;
  localparam logic [7:0] W_RES  = 8'h01;

  function automatic logic [7:0] obs();
    return {instr_ready, reg_en, f_load, f_reg_e, f_clr, res_valid};
  endfunction

  // Offer one instruction for a single edge; returns at the falling edge after it.
  task automatic issue(input logic [7:0] ins);
    instr_valid = 1'b1;
    instr       = ins;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (obs() !== W_ZERO) begin bad++; $display("FAIL reset_async: got %h want %h", obs(), W_ZERO); end
    repeat (2) @(negedge clk);
    total++;
    if (obs() !== W_ZERO) begin bad++; $display("FAIL reset_held: got %h want %h", obs(), W_ZERO); end
    rst = 1'b0;
    #1;
    total++;
    if (obs() !== W_ZERO) begin bad++; $display("FAIL ready_before_edge: got %h want %h", obs(), W_ZERO); end
    @(negedge clk);
    total++;
    if (obs() !== W_IDLE) begin bad++; $display("FAIL ready_first_edge: got %h want %h", obs(), W_IDLE); end
  endtask

  task automatic test_lde_imm();
    issue(8'h40);
    total++;
    if (obs() !== W_LIMM) begin bad++; $display("FAIL lde_imm_exec: got %h want %h", obs(), W_LIMM); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== W_IDLE) begin bad++; $display("FAIL lde_imm_after[%0d]: got %h want %h", i, obs(), W_IDLE); end
    end
  endtask

  task automatic test_opcodes();
    logic [7:0] ins_t [8] = '{8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hE0, 8'h5F, 8'hE7};
    logic [7:0] exp_t [8] = '{W_LSW, W_LIMM, W_B, W_D, W_CLR, W_ADDA, W_LIMM, W_ADDA};
    for (int i = 0; i < 8; i++) begin
      issue(ins_t[i]);
      total++;
      if (obs() !== exp_t[i]) begin bad++; $display("FAIL opcode %h: got %h want %h", ins_t[i], obs(), exp_t[i]); end
      @(negedge clk);
      total++;
      if (obs() !== W_IDLE) begin bad++; $display("FAIL opcode %h return: got %h want %h", ins_t[i], obs(), W_IDLE); end
    end
  endtask

  // MAC, with a second instruction offered from MAC_B onward that must wait for IDLE.
  task automatic test_mac_busy();
    logic [7:0] exp_t [4] = '{W_B, W_D, W_RES, W_IDLE};
    issue(8'hC0);
    instr_valid = 1'b1;
    instr       = 8'h20;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs() !== exp_t[i]) begin bad++; $display("FAIL mac_step[%0d]: got %h want %h", i, obs(), exp_t[i]); end
      if (i < 3) @(negedge clk);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    total++;
    if (obs() !== W_LSW) begin bad++; $display("FAIL busy_then_accept: got %h want %h", obs(), W_LSW); end
    @(negedge clk);
    total++;
    if (obs() !== W_IDLE) begin bad++; $display("FAIL busy_return: got %h want %h", obs(), W_IDLE); end
  endtask

  task automatic test_nop();
    logic [7:0] ins_t [3] = '{8'h05, 8'h00, 8'h0F};
    int         len_t [3] = '{6, 1, 16};
    for (int k = 0; k < 3; k++) begin
      issue(ins_t[k]);
      for (int i = 0; i < len_t[k]; i++) begin
        total++;
        if (obs() !== W_ZERO) begin bad++; $display("FAIL nop %h cycle %0d: got %h want %h", ins_t[k], i, obs(), W_ZERO); end
        @(negedge clk);
      end
      total++;
      if (obs() !== W_IDLE) begin bad++; $display("FAIL nop %h end: got %h want %h", ins_t[k], obs(), W_IDLE); end
    end
  endtask

  task automatic test_back_to_back();
    logic prev_res = 1'b0;
    instr_valid = 1'b1;
    instr       = 8'hE0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== ((i % 2 == 0) ? W_ADDA : W_IDLE)) begin
        bad++; $display("FAIL b2b[%0d]: got %h want %h", i, obs(), (i % 2 == 0) ? W_ADDA : W_IDLE);
      end
      total++;
      if (prev_res && res_valid) begin bad++; $display("FAIL b2b_res_twice[%0d]: got 1 want 0", i); end
      prev_res = res_valid;
    end
    instr_valid = 1'b0;
    @(negedge clk);
    total++;
    if (obs() !== W_IDLE) begin bad++; $display("FAIL b2b_stop: got %h want %h", obs(), W_IDLE); end
  endtask

  task automatic test_reset_mid_mac();
    logic [7:0] exp_t [4] = '{W_B, W_D, W_RES, W_IDLE};
    issue(8'hC0);
    @(negedge clk);
    total++;
    if (obs() !== W_D) begin bad++; $display("FAIL pre_reset_mac_d: got %h want %h", obs(), W_D); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs() !== W_ZERO) begin bad++; $display("FAIL mid_mac_async: got %h want %h", obs(), W_ZERO); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== W_ZERO) begin bad++; $display("FAIL mid_mac_held[%0d]: got %h want %h", i, obs(), W_ZERO); end
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (obs() !== W_IDLE) begin bad++; $display("FAIL mid_mac_release: got %h want %h", obs(), W_IDLE); end
    issue(8'hC0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs() !== exp_t[i]) begin bad++; $display("FAIL mac_after_reset[%0d]: got %h want %h", i, obs(), exp_t[i]); end
      if (i < 3) @(negedge clk);
    end
  endtask

  // Mid-WAIT reset also clears outputs immediately and abandons the count.
  task automatic test_reset_mid_wait();
    issue(8'h0A);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs() !== W_ZERO) begin bad++; $display("FAIL mid_wait_async: got %h want %h", obs(), W_ZERO); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (obs() !== W_IDLE) begin bad++; $display("FAIL mid_wait_release: got %h want %h", obs(), W_IDLE); end
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 8'h00;
    test_reset();
    test_lde_imm();
    test_opcodes();
    test_mac_busy();
    test_nop();
    test_back_to_back();
    test_reset_mid_mac();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
